// File: rtl/sine_pkg.sv
// sine_pkg: shared constants and the elaboration-time table generator for
// the LUT-based sine evaluator.
//   STEPS_PER_RAD : address steps per radian (1 LSB = 1/300 rad)
//   PERIOD        : address steps per 2*pi, round(2*pi*300)
//   FRAC_BITS     : fractional bits of the Q16.16 result
//   TBL_W / IDX_W : table entry width and table index width
//   sine_entry()  : constant function, round(2^FRAC_BITS * sin(k/STEPS_PER_RAD))
package sine_pkg;

   localparam int  STEPS_PER_RAD = 300;
   localparam int  PERIOD        = 1885;
   localparam int  FRAC_BITS     = 16;
   localparam int  TBL_W         = 18;
   localparam int  IDX_W         = 11;
   localparam real PI            = 3.14159265358979323846;

   // Only ever evaluated at elaboration with a constant argument.
   // The angle is folded into [-pi/2, pi/2] so a short Taylor series
   // converges to full double precision. Rounding is half away from zero.
   function automatic int sine_entry(input int k);
      real x;
      real term;
      real sum;
      real scaled;
      int  res;
      x = real'(k) / real'(STEPS_PER_RAD);
      if (x > PI)
         x = x - 2.0 * PI;
      if (x > PI / 2.0)
         x = PI - x;
      else if (x < -PI / 2.0)
         x = -PI - x;
      term = x;
      sum  = x;
      for (int n = 1; n < 12; n++) begin
         term = -term * x * x / real'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      scaled = sum * real'(1 << FRAC_BITS);
      if (scaled < 0.0)
         res = -$rtoi(0.5 - scaled);
      else
         res = $rtoi(scaled + 0.5);
      return res;
   endfunction

endpackage

// File: rtl/sine_rom.sv
// sine_rom: combinational one-period sine table.
//   idx   : table index, valid range 0..PERIOD-1
//   value : signed round(65536*sin(idx/300)), range -65536..65536
// Indices past the end of the table (never produced by the range
// reduction upstream) read as zero.
module sine_rom
   import sine_pkg::*;
(
   input  logic        [IDX_W-1:0] idx,
   output logic signed [TBL_W-1:0] value
);

   logic signed [TBL_W-1:0] tbl [PERIOD];

   // Each entry is a localparam so the trig is folded away at elaboration.
   for (genvar k = 0; k < PERIOD; k++) begin : g_tbl
      localparam logic signed [TBL_W-1:0] ENTRY = TBL_W'(sine_entry(k));
      assign tbl[k] = ENTRY;
   end

   always_comb begin
      value = '0;
      if (idx < IDX_W'(PERIOD))
         value = tbl[idx];
   end

endmodule

// File: rtl/sine_calculator.sv
// sine_calculator: fixed-point sine, 1-cycle latency.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset, clears data_out at once
//   address  : signed angle, 1 LSB = 1/300 rad
//   data_out : registered signed sin(address/300) in Q16.16
// The angle is split into sign and magnitude, the magnitude is reduced
// modulo one period and looked up, and the sign is applied afterwards,
// which makes the function exactly odd.
module sine_calculator
   import sine_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [ADDR_W-1:0] address,
   output logic signed [DATA_W-1:0] data_out
);

   logic                     neg;
   logic        [ADDR_W-1:0] addr_u;
   logic        [ADDR_W-1:0] mag;
   logic        [IDX_W-1:0]  idx;
   logic signed [TBL_W-1:0]  tbl_val;
   logic signed [DATA_W-1:0] ext;
   logic signed [DATA_W-1:0] result;

   assign addr_u = address;
   assign neg    = address[ADDR_W-1];

   // Two's-complement magnitude taken as unsigned: the most negative
   // input maps to 2^(ADDR_W-1) without overflow.
   assign mag = neg ? (~addr_u + ADDR_W'(1)) : addr_u;
   assign idx = IDX_W'(mag % ADDR_W'(PERIOD));

   sine_rom u_rom (
      .idx   (idx),
      .value (tbl_val)
   );

   assign ext    = {{(DATA_W-TBL_W){tbl_val[TBL_W-1]}}, tbl_val};
   assign result = neg ? -ext : ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         data_out <= '0;
      else
         data_out <= result;
   end

endmodule

// File: tb/tb_sine_calculator.sv
// tb_sine_calculator: directed vectors for sine_calculator, including
// reset, point values, odd symmetry, a +/-5 rad sweep, wrap and extreme
// addresses, and an asynchronous reset in the middle of a stream.
module tb_sine_calculator;

   logic               tb_clk;
   logic               rst_n;
   logic signed [31:0] address;
   logic signed [31:0] data_out;

   int n_vec = 0;
   int n_bad = 0;

   sine_calculator #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk      (tb_clk),
      .rst_n    (rst_n),
      .address  (address),
      .data_out (data_out)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp, input int tol);
      int diff;
      n_vec++;
      if ($isunknown(got)) begin
         n_bad++;
         $display("FAIL %s: got %h (unknown) want %h", tag, got, exp);
      end else begin
         diff = int'(got) - int'(exp);
         if (diff < 0) diff = -diff;
         if (diff > tol) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (tol %0d)", tag, got, exp, tol);
         end
      end
   endtask

   function automatic int round_q16(input real v);
      real s;
      s = v * 65536.0;
      return (s < 0.0) ? -$rtoi(0.5 - s) : $rtoi(s + 0.5);
   endfunction

   // Reference range reduction and lookup using the host math library.
   function automatic int ref_val(input longint a);
      longint m;
      int     r;
      m = (a < 0) ? -a : a;
      r = round_q16($sin(real'(m % 1885) / 300.0));
      return (a < 0) ? -r : r;
   endfunction

   // Apply one address just after an edge, return just after the next.
   task automatic step(input logic signed [31:0] a);
      address = a;
      @(posedge tb_clk);
      #1;
   endtask

   typedef struct {
      int    addr;
      int    exp;
   } vec_t;

   vec_t pts[] = '{
      '{0,      32'h0000_0000},
      '{300,    32'h0000_D76B},
      '{471,    32'h0001_0000},
      '{942,    32'h0000_0068},
      '{-300,   32'hFFFF_2895},
      '{1500,   32'hFFFF_0A84},
      '{-1500,  32'h0000_F57C},
      '{1885,   32'h0000_0000},
      '{-1885,  32'h0000_0000},
      '{2185,   32'h0000_D76B},
      '{-471,   32'hFFFF_0000}
   };

   initial begin
      int prev;
      int cur;

      // Reset held: output zero regardless of address and clock edges.
      rst_n   = 1'b0;
      address = 32'sd300;
      #2;
      check("rst_async", data_out, 32'h0, 0);
      #20;
      check("rst_hold", data_out, 32'h0, 0);
      @(negedge tb_clk);
      rst_n = 1'b1;
      #1;
      check("rst_rel_noedge", data_out, 32'h0, 0);
      @(posedge tb_clk);
      #1;
      check("rst_first", data_out, 32'h0000_D76B, 0);

      foreach (pts[i]) begin
         step(pts[i].addr);
         check($sformatf("pt_%0d", pts[i].addr), data_out, pts[i].exp, 0);
      end

      // Sweep -5.0..5.0 rad in 0.1 steps; old value must hold until the
      // edge and the new one appear right after it.
      prev = 32'hFFFF_0000;
      for (int i = -50; i <= 50; i++) begin
         address = i * 30;
         @(negedge tb_clk);
         check($sformatf("sw_hold_%0d", i), data_out, prev, 2);
         @(posedge tb_clk);
         #1;
         cur = round_q16($sin(real'(i) * 0.1));
         check($sformatf("sw_%0d", i), data_out, cur, 2);
         prev = cur;
      end

      // Extreme addresses through the modulo.
      step(32'sh7FFF_FFFF);
      check("max_pos", data_out, ref_val(64'sd2147483647), 1);
      step(32'sh8000_0000);
      check("max_neg", data_out, ref_val(-64'sd2147483648), 1);
      step(32'sh8000_0001);
      check("max_neg1", data_out, ref_val(-64'sd2147483647), 1);
      step(100000);
      check("big_pos", data_out, ref_val(64'sd100000), 1);

      // Async reset between edges while streaming.
      step(300);
      check("pre_rst", data_out, 32'h0000_D76B, 0);
      address = 471;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst", data_out, 32'h0, 0);
      @(posedge tb_clk);
      #1;
      check("mid_rst_hold", data_out, 32'h0, 0);
      @(negedge tb_clk);
      rst_n = 1'b1;
      @(posedge tb_clk);
      #1;
      check("post_rst", data_out, 32'h0001_0000, 0);
      step(-1500);
      check("post_rst2", data_out, 32'h0000_F57C, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/sine_calculator.md
Name: sine_calculator

Overview:
- Fixed-point sine evaluator. Angle input is in units of 1/300 rad: address = round(x_rad*300). Result is Q16.16.
- Used as a LUT-based math primitive in the project datapath.
- One registered output stage, 1-cycle latency.

Parameters:
- ADDR_W, 32, width of the signed angle input.
- DATA_W, 32, width of the signed Q16.16 result.
- FRAC_BITS, 16, number of fractional bits in the result.
- STEPS_PER_RAD, 300, number of address steps per radian.
- PERIOD, 1885, address steps per 2*pi (round(2*pi*300)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- address  input  ADDR_W  signed angle, 1 LSB = 1/300 rad.
- data_out  output  DATA_W  signed sin(address/300) in Q16.16.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: while rst_n=0, data_out=0 immediately, without waiting for a clock edge. First update is on the first rising clk edge after rst_n goes high.
- Latency: address is sampled on the rising edge of clk. data_out holds the result for that sample from that edge until the next edge (1 cycle).
- No handshake: every cycle produces a new result. A constant address gives a constant output.

Range reduction (combinational, before the register):
- mag = |address|, computed as an unsigned ADDR_W value, so -2^31 maps to 2^31 with no overflow.
- neg = address[ADDR_W-1].
- idx = mag mod PERIOD, range 0..1884.

Table:
- tbl[k] = round(65536*sin(k/300)) for k = 0..1884.
- Stored as 18-bit signed values in the range -65536..65536.
- Contents are generated at elaboration by a constant function; no runtime trigonometry.

Output:
- data_out = neg ? -sext(tbl[idx]) : sext(tbl[idx]).
- This makes the function exactly odd: f(-a) = -f(a).

Boundary conditions:
- address=0 -> 0.
- address = ±PERIOD -> 0.
- address = 2^31-1 and -2^31 reduce through the modulo with no X and no overflow.
- Peak value 0x00010000 is representable and must not saturate or wrap.
- Reset asserted mid-stream clears data_out at once. The in-flight sample is discarded.

Decomposition:
- Package sine_pkg holds STEPS_PER_RAD, PERIOD, FRAC_BITS, the table entry width (18), and the constant function that computes a table entry.
- Sub-module sine_rom is a pure combinational lookup: input idx[10:0], output signed [17:0] value.
- sine_calculator holds the sign/magnitude handling, the modulo, the negation and the output register.

Test Plan:
- Reset: hold rst_n=0 with address=300 -> data_out=0x00000000. Release reset, then one edge -> 0x0000D76B.
- Point values, one edge each:
  - address=0 -> 0x00000000.
  - address=300 -> 0x0000D76B (55147).
  - address=471 -> 0x00010000.
  - address=942 -> 0x00000068.
- Odd symmetry: address=-300 -> 0xFFFF2895. Address=1500 -> 0xFFFF0A84. Address=-1500 -> 0x0000F57C.
- Sweep: x from -5.0 to 5.0 in steps of 0.1, address = x*300, sampled one edge later. |data_out/65536 - sin(x)| must not exceed 2^-15 at every point, with output exactly 1 cycle after each address change.
- Wrap: address=1885 -> 0. Address=2185 -> 0x0000D76B. Address=2^31-1 and -2^31 -> must equal a software model of the range reduction, with no X.
- Async reset mid-run: assert rst_n between edges while streaming -> data_out goes to 0 before the next edge. Streaming resumes correctly after release.
